ddr_burst_arbiter: RTL and testbench

//  Shares the single DDRAM Avalon-style port between three clients: frame-buffer reader (R0),
//  ROM download writer (W) and tile/sample ROM reader (R1). Sits between Main's client logic
//  and the emu-level DDRAM pins. Serialises requests with fixed priority, forwards one burst at
//  a time and steers read-data beats back to the owning client. Keeps bursts atomic across reset.

---
 rtl/ddr_burst_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_arbiter.sv
// rtl/ddr_burst_arbiter.sv - fixed-priority DDRAM burst arbiter for two readers and one writer
module ddr_burst_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r0_rd,
  input  logic [ADDR_W-1:0]     r0_addr,
  input  logic [BURST_W-1:0]    r0_burst,
  output logic                  r0_wait,
  output logic                  r0_valid,
  input  logic                  r1_rd,
  input  logic [ADDR_W-1:0]     r1_addr,
  input  logic [BURST_W-1:0]    r1_burst,
  output logic                  r1_wait,
  output logic                  r1_valid,
  input  logic                  w_wr,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_W-1:0]     w_din,
  input  logic [DATA_W/8-1:0]   w_mask,
  output logic                  w_wait,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  ddr_rd,
  output logic                  ddr_wr,
  output logic [ADDR_W-1:0]     ddr_addr,
  output logic [BURST_W-1:0]    ddr_burst,
  output logic [DATA_W-1:0]     ddr_din,
  output logic [DATA_W/8-1:0]   ddr_mask,
  input  logic                  ddr_wait,
  input  logic                  ddr_valid,
  input  logic [DATA_W-1:0]     ddr_dout
);
  // Counter is one bit wider than the burst field so a full-size burst never wraps.
  localparam int CNT_W = BURST_W + 1;

  typedef enum logic [2:0] {IDLE, RCMD, RDATA, WCMD, DRAIN} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             owner_r1;
  logic             gap;
  logic             grant_ok;
  logic             beat;

  // A zero burst request still moves one beat.
  function automatic logic [BURST_W-1:0] burst_nz(input logic [BURST_W-1:0] b);
    return (b == '0) ? BURST_W'(1) : b;
  endfunction

  assign rd_data = ddr_dout;

  // Grants happen only in IDLE, outside reset, and never in the turnaround cycle after a transaction.
  assign grant_ok = (state == IDLE) && !reset && !gap;

  // A read beat is consumed only while beats are still owed.
  assign beat = ddr_valid && (cnt != '0);

  // Next-state, beat counting, client waits and read-valid steering.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    r0_wait    = 1'b1;
    r1_wait    = 1'b1;
    w_wait     = 1'b1;
    r0_valid   = 1'b0;
    r1_valid   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (grant_ok) begin
          if (r0_rd) begin
            r0_wait    = 1'b0;
            state_next = RCMD;
            cnt_next   = {1'b0, burst_nz(r0_burst)};
          end else if (w_wr) begin
            w_wait     = 1'b0;
            state_next = WCMD;
          end else if (r1_rd) begin
            r1_wait    = 1'b0;
            state_next = RCMD;
            cnt_next   = {1'b0, burst_nz(r1_burst)};
          end
        end
      end
      RCMD, RDATA: begin
        if (beat) begin
          cnt_next = cnt - CNT_W'(1);
          r0_valid = !reset && !owner_r1;
          r1_valid = !reset && owner_r1;
        end
        if (state == RDATA || !ddr_wait) begin
          // Command is on the bus: beats are owed, so reset must drain them.
          if (cnt_next == '0) begin
            state_next = IDLE;
          end else if (reset) begin
            state_next = DRAIN;
          end else begin
            state_next = RDATA;
          end
        end else if (reset) begin
          // Never accepted by the DDR: safe to abandon.
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      WCMD: begin
        if (!ddr_wait || reset) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (beat) begin
          cnt_next = cnt - CNT_W'(1);
        end
        if (cnt_next == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and beat counter; reset behaviour is resolved in the next-state logic so drains survive it.
  always_ff @(posedge clock) begin
    state <= state_next;
    cnt   <= cnt_next;
  end

  // Registered DDR command, captured request fields, owner and turnaround flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      ddr_rd    <= 1'b0;
      ddr_wr    <= 1'b0;
      gap       <= 1'b0;
      owner_r1  <= 1'b0;
      ddr_addr  <= '0;
      ddr_burst <= '0;
      ddr_din   <= '0;
      ddr_mask  <= '0;
    end else begin
      ddr_rd <= (state_next == RCMD);
      ddr_wr <= (state_next == WCMD);
      gap    <= (state != IDLE) && (state_next == IDLE);
      if (!r0_wait) begin
        ddr_addr  <= r0_addr;
        ddr_burst <= burst_nz(r0_burst);
        owner_r1  <= 1'b0;
      end else if (!w_wait) begin
        ddr_addr  <= w_addr;
        ddr_burst <= BURST_W'(1);
        ddr_din   <= w_din;
        ddr_mask  <= w_mask;
      end else if (!r1_wait) begin
        ddr_addr  <= r1_addr;
        ddr_burst <= burst_nz(r1_burst);
        owner_r1  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb/tb_ddr_burst_arbiter.sv - randomized self-checking bench for ddr_burst_arbiter
module tb_ddr_burst_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        r0_rd, r0_wait, r0_valid;
  logic [31:0] r0_addr;
  logic [7:0]  r0_burst;
  logic        r1_rd, r1_wait, r1_valid;
  logic [31:0] r1_addr;
  logic [7:0]  r1_burst;
  logic        w_wr, w_wait;
  logic [31:0] w_addr;
  logic [63:0] w_din;
  logic [7:0]  w_mask;
  logic [63:0] rd_data;
  logic        ddr_rd, ddr_wr;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_burst;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_mask;
  logic        ddr_wait, ddr_valid;
  logic [63:0] ddr_dout;

  always #5 clock = ~clock;

  ddr_burst_arbiter dut (
    .clock(clock), .reset(reset),
    .r0_rd(r0_rd), .r0_addr(r0_addr), .r0_burst(r0_burst), .r0_wait(r0_wait), .r0_valid(r0_valid),
    .r1_rd(r1_rd), .r1_addr(r1_addr), .r1_burst(r1_burst), .r1_wait(r1_wait), .r1_valid(r1_valid),
    .w_wr(w_wr), .w_addr(w_addr), .w_din(w_din), .w_mask(w_mask), .w_wait(w_wait),
    .rd_data(rd_data),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr), .ddr_burst(ddr_burst),
    .ddr_din(ddr_din), .ddr_mask(ddr_mask),
    .ddr_wait(ddr_wait), .ddr_valid(ddr_valid), .ddr_dout(ddr_dout)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  burst;
    logic [63:0] din;
    logic [7:0]  mask;
    int          owner;
  } cmd_t;

  int   checks = 0;
  int   errors = 0;
  cmd_t exp_cmd[$];
  int   exp_grant[$];
  int   got_grant[$];
  int   exp_beats[3];
  int   got_beats[3];
  int   beats_owed = 0;
  int   cur_owner = -1;
  int   acc_hold = 0;
  int   fixed_hold = 0;
  int   max_hold = 3;
  int   valid_pct = 100;
  bit   stray_en = 1'b0;
  int   cyc = 0;
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  int   w_stream_left = 0;
  int   wr_acc_cyc[$];
  bit   g_r0, g_w, g_r1;
  int   drain_last_cyc = 0;
  int   drain_wait_bad = 0;
  int   r0_grant_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] nz(input logic [7:0] b);
    return (b == 8'd0) ? 8'd1 : b;
  endfunction

  task automatic new_read(input int id, input logic [31:0] addr, input logic [7:0] b);
    cmd_t c;
    c.wr = 1'b0; c.addr = addr; c.burst = nz(b); c.din = '0; c.mask = '0; c.owner = id;
    exp_cmd.push_back(c);
    exp_grant.push_back(id);
    exp_beats[id] += int'(nz(b));
    if (id == 0) begin r0_addr = addr; r0_burst = b; r0_rd = 1'b1; end
    else begin r1_addr = addr; r1_burst = b; r1_rd = 1'b1; end
  endtask

  task automatic new_write();
    cmd_t c;
    c.wr = 1'b1; c.addr = $urandom; c.burst = 8'd1; c.din = {$urandom, $urandom};
    c.mask = 8'($urandom); c.owner = 1;
    exp_cmd.push_back(c);
    exp_grant.push_back(1);
    w_addr = c.addr; w_din = c.din; w_mask = c.mask; w_wr = 1'b1;
  endtask

  // One clock: DDR responder drives, outputs are sampled against the model, then clients react.
  task automatic tick();
    cmd_t c;
    #1;
    if (ddr_rd || ddr_wr) ddr_wait = (acc_hold > 0);
    else ddr_wait = 1'($urandom_range(0, 1));
    if (beats_owed > 0) ddr_valid = ($urandom_range(1, 100) <= valid_pct);
    else ddr_valid = stray_en && !ddr_rd && !ddr_wr && ($urandom_range(0, 1) == 1);
    ddr_dout = {$urandom, $urandom};
    #1;
    if (reset && beats_owed > 0) cur_owner = -1;
    if (cur_owner < 0 && beats_owed > 0 && !(r0_wait && r1_wait && w_wait)) drain_wait_bad++;
    g_r0 = !r0_wait; g_w = !w_wait; g_r1 = !r1_wait;
    if ((int'(g_r0) + int'(g_w) + int'(g_r1)) > 1) check("single_grant", {g_r0, g_w, g_r1}, 0);
    if (g_r0) begin got_grant.push_back(0); r0_grant_cyc = cyc; end
    if (g_w) got_grant.push_back(1);
    if (g_r1) got_grant.push_back(2);
    if (ddr_valid) begin
      if (beats_owed > 0) begin
        check("beat_r0", r0_valid, cur_owner == 0);
        check("beat_r1", r1_valid, cur_owner == 2);
        if (cur_owner >= 0) begin
          check("beat_data", rd_data, ddr_dout);
          got_beats[cur_owner]++;
        end else drain_last_cyc = cyc;
        beats_owed--;
      end else check("stray_valid", {r0_valid, r1_valid}, 2'b00);
    end else check("no_valid", {r0_valid, r1_valid}, 2'b00);
    if (ddr_rd) rd_cycles++;
    if (ddr_wr) wr_cycles++;
    if (ddr_rd || ddr_wr) begin
      if (exp_cmd.size() == 0) check("cmd_unexpected", {ddr_rd, ddr_wr}, 0);
      else begin
        c = exp_cmd[0];
        check("cmd_rd", ddr_rd, !c.wr);
        check("cmd_wr", ddr_wr, c.wr);
        check("cmd_addr", ddr_addr, c.addr);
        check("cmd_burst", ddr_burst, c.burst);
        if (c.wr) begin
          check("cmd_din", ddr_din, c.din);
          check("cmd_mask", ddr_mask, c.mask);
        end
        if (!ddr_wait) begin
          void'(exp_cmd.pop_front());
          if (c.wr) wr_acc_cyc.push_back(cyc);
          else begin beats_owed = int'(c.burst); cur_owner = c.owner; end
          acc_hold = (fixed_hold >= 0) ? fixed_hold : $urandom_range(0, max_hold);
        end else acc_hold--;
      end
    end
    @(posedge clock);
    cyc++;
    #1;
    if (g_r0) r0_rd = 1'b0;
    if (g_r1) r1_rd = 1'b0;
    if (g_w) begin
      if (w_stream_left > 0) begin w_stream_left--; new_write(); end
      else w_wr = 1'b0;
    end
  endtask

  task automatic clear_round();
    exp_grant.delete(); got_grant.delete();
    for (int k = 0; k < 3; k++) begin exp_beats[k] = 0; got_beats[k] = 0; end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_cmd.size() > 0 || beats_owed > 0 || r0_rd || r1_rd || w_wr) && n < 3000) begin
      tick(); n++;
    end
    check({tag, "_timeout"}, n >= 3000, 0);
    tick(); tick();
  endtask

  task automatic compare_round(input string tag);
    check({tag, "_grant_count"}, got_grant.size(), exp_grant.size());
    for (int i = 0; i < got_grant.size() && i < exp_grant.size(); i++)
      check({tag, "_grant_order"}, got_grant[i], exp_grant[i]);
    for (int k = 0; k < 3; k++) check({tag, "_beats"}, got_beats[k], exp_beats[k]);
  endtask

  task automatic run_round(input string tag, input int mask, input logic [31:0] a0, input logic [7:0] b0,
                           input logic [31:0] a1, input logic [7:0] b1);
    clear_round();
    if (mask[0]) new_read(0, a0, b0);
    if (mask[1]) new_write();
    if (mask[2]) new_read(2, a1, b1);
    wait_idle(tag);
    compare_round(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; r0_rd = 1'b1; r1_rd = 1'b1; w_wr = 1'b1;
    r0_addr = '0; r0_burst = 8'd2; r1_addr = '0; r1_burst = 8'd2;
    w_addr = '0; w_din = '0; w_mask = '0;
    ddr_wait = 1'b0; ddr_valid = 1'b1; ddr_dout = '0;
    repeat (3) @(posedge clock);
    #3;
    check("rst_ddr_rd", ddr_rd, 0);
    check("rst_ddr_wr", ddr_wr, 0);
    check("rst_r0_wait", r0_wait, 1);
    check("rst_r1_wait", r1_wait, 1);
    check("rst_w_wait", w_wait, 1);
    check("rst_valids", {r0_valid, r1_valid}, 2'b00);
    @(posedge clock);
    #1;
    reset = 1'b0; r0_rd = 1'b0; r1_rd = 1'b0; w_wr = 1'b0; ddr_valid = 1'b0;

    // Single R0 burst of 4 with an always-ready DDR.
    fixed_hold = 0; acc_hold = 0; valid_pct = 100; rd_cycles = 0;
    run_round("t1", 1, 32'h1000, 8'd4, 32'h0, 8'd0);
    check("t1_rd_cycles", rd_cycles, 1);

    // All three clients together.
    fixed_hold = -1; max_hold = 2; valid_pct = 70;
    run_round("t2", 7, $urandom, 8'd3, $urandom, 8'd2);

    // Write held off by the DDR for five cycles.
    fixed_hold = 5; acc_hold = 5; wr_cycles = 0;
    run_round("t3", 2, 32'h0, 8'd0, 32'h0, 8'd0);
    check("t3_wr_cycles", wr_cycles, 6);

    // Reset in the middle of an R1 burst of 8, with R0 waiting behind it.
    fixed_hold = 0; acc_hold = 0; valid_pct = 100; drain_wait_bad = 0;
    clear_round();
    new_read(2, $urandom, 8'd8);
    begin
      int n = 0;
      while (got_beats[2] < 3 && n < 200) begin tick(); n++; end
    end
    check("t4_reach_beat3", got_beats[2], 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    new_read(0, $urandom, 8'd2);
    r0_grant_cyc = -1;
    wait_idle("t4");
    check("t4_r1_beats", got_beats[2], 3);
    check("t4_r0_beats", got_beats[0], 2);
    check("t4_drain_waits", drain_wait_bad, 0);
    check("t4_grant_after_drain", r0_grant_cyc > drain_last_cyc, 1);

    // Stray beats while idle, then a zero-length R1 burst.
    stray_en = 1'b1;
    repeat (6) tick();
    run_round("t5", 4, 32'h0, 8'd0, 32'h2000, 8'd0);
    stray_en = 1'b0;

    // Sixteen back-to-back writes.
    fixed_hold = 0; acc_hold = 0; wr_acc_cyc.delete();
    clear_round();
    w_stream_left = 15;
    new_write();
    wait_idle("t6");
    compare_round("t6");
    check("t6_writes", wr_acc_cyc.size(), 16);
    for (int i = 1; i < wr_acc_cyc.size(); i++)
      check("t6_interval", wr_acc_cyc[i] - wr_acc_cyc[i-1], 3);

    // Randomized mixes.
    for (int r = 0; r < 40; r++) begin
      fixed_hold = -1;
      max_hold = $urandom_range(0, 3);
      valid_pct = $urandom_range(30, 100);
      stray_en = 1'($urandom_range(0, 1));
      run_round("rnd", $urandom_range(1, 7), $urandom, 8'($urandom_range(0, 6)),
                $urandom, 8'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
